// File: rtl/game_pkg.sv
// game_pkg: shared key codes, PS/2 prefix codes and receiver types for the game datapath
package game_pkg;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} ps2_state_t;
    typedef struct packed {
        logic brk;
        logic ext;
    } ps2_prefix_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises and filters the PS/2 lines and deserialises 11-bit frames
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   ps2_clk, ps2_dat  raw asynchronous PS/2 lines
//   byte_valid        combinational strobe: good frame completed this cycle
//   rx_byte           received data byte, valid with byte_valid
//   err               combinational strobe: parity, stop-bit or timeout error
module ps2_frame_rx
    import game_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] sc, sd;
    logic                   sclk, dat, fclk, fall, timeout, stop_ok;
    logic [FW-1:0]          fcnt;
    logic [TW-1:0]          tcnt;
    logic [2:0]             bitc;
    logic [7:0]             shreg;
    logic                   par;
    ps2_state_t             state;

    assign sclk = sc[SYNC_STAGES-1];
    assign dat  = sd[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc   <= '1;
            sd   <= '1;
            fclk <= 1'b1;
            fcnt <= '0;
            fall <= 1'b0;
        end else begin
            sc   <= {sc[SYNC_STAGES-2:0], ps2_clk};
            sd   <= {sd[SYNC_STAGES-2:0], ps2_dat};
            // fall is registered together with fclk so both move in the same cycle
            fall <= (sclk != fclk) && (fcnt == FLAST) && !sclk;
            if (sclk == fclk) fcnt <= '0;
            else if (fcnt == FLAST) begin
                fclk <= sclk;
                fcnt <= '0;
            end else fcnt <= fcnt + 1'b1;
        end
    end

    // a falling edge always beats a timeout in the same cycle
    assign timeout    = (state != S_IDLE) && !fall && (tcnt == TMAX);
    assign stop_ok    = dat && (^{shreg, par});
    assign byte_valid = fall && (state == S_STOP) && stop_ok;
    assign err        = timeout || (fall && (state == S_STOP) && !stop_ok);
    assign rx_byte    = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            bitc  <= '0;
            shreg <= '0;
            par   <= 1'b0;
            tcnt  <= '0;
        end else begin
            if (fall || state == S_IDLE) tcnt <= '0;
            else if (tcnt != TMAX) tcnt <= tcnt + 1'b1;
            if (timeout) state <= S_IDLE;
            else if (fall) begin
                case (state)
                    S_IDLE: if (!dat) begin
                        state <= S_DATA;
                        bitc  <= '0;
                    end
                    S_DATA: begin
                        shreg <= {dat, shreg[7:1]};
                        bitc  <= bitc + 1'b1;
                        if (bitc == 3'd7) state <= S_PAR;
                    end
                    S_PAR: begin
                        par   <= dat;
                        state <= S_STOP;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 make/break byte streams into a held-key level for the game block
// Ports:
//   i_clk, i_rst_n        system clock, asynchronous active-low reset
//   i_ps2_clk, i_ps2_dat  raw asynchronous PS/2 lines
//   o_key                 scan code of the held key, 8'h00 when none
//   o_key_valid           one-cycle pulse per accepted make (typematic repeats included)
//   o_frame_err           one-cycle pulse per parity, stop-bit or timeout error
module ps2_key_decoder
    import game_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_key,
    output logic       o_key_valid,
    output logic       o_frame_err
);
    logic        byte_valid, err, is_key;
    logic [7:0]  rx_byte;
    ps2_prefix_t pfx;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .ps2_clk   (i_ps2_clk),
        .ps2_dat   (i_ps2_dat),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .err       (err)
    );

    assign is_key = (rx_byte != PS2_EXT) && (rx_byte != PS2_BRK);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_key       <= '0;
            o_key_valid <= 1'b0;
            o_frame_err <= 1'b0;
            pfx         <= '0;
        end else begin
            o_key_valid <= byte_valid && is_key && !pfx.brk;
            o_frame_err <= err;
            if (err) pfx <= '0;
            else if (byte_valid) begin
                if (rx_byte == PS2_EXT) pfx.ext <= 1'b1;
                else if (rx_byte == PS2_BRK) pfx.brk <= 1'b1;
                else begin
                    // ext only records the prefix; E0-prefixed keys decode like plain ones
                    if (pfx != '0) pfx <= '0;
                    if (!pfx.brk) o_key <= rx_byte;
                    else if (rx_byte == o_key) o_key <= '0;
                end
            end
        end
    end
endmodule
